// File: rtl/soft_body_integrator.sv
// Semi-implicit Euler step for NUM_BODIES soft bodies, one node per clock.
// Inputs are latched on accept; outputs update atomically when the step completes.
module soft_body_integrator #(
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int NUM_NODES     = 4,
    parameter int NUM_BODIES    = 2,
    parameter int DT            = 1,
    parameter int GRAVITY       = -1,
    parameter int MASS_SHIFT    = 0,
    parameter int DAMP_SHIFT    = 0
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            begin_in,
    input  logic signed [POSITION_SIZE-1:0] nodes_in      [NUM_BODIES][2][NUM_NODES],
    input  logic signed [VELOCITY_SIZE-1:0] velocities_in [NUM_BODIES][2][NUM_NODES],
    input  logic signed [FORCE_SIZE-1:0]    forces_in     [NUM_BODIES][2][NUM_NODES],
    input  logic [NUM_BODIES*NUM_NODES-1:0] pin_mask,
    output logic signed [POSITION_SIZE-1:0] nodes_out      [NUM_BODIES][2][NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] velocities_out [NUM_BODIES][2][NUM_NODES],
    output logic                            busy_out,
    output logic                            result_out,
    output logic                            sat_out
);

    localparam int MAX_PV  = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
    localparam int MAX_PVF = (MAX_PV > FORCE_SIZE) ? MAX_PV : FORCE_SIZE;
    localparam int W       = MAX_PVF + $clog2(DT) + 3;
    localparam int NW      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int BW      = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1;

    localparam int P_MAX_I = (1 << (POSITION_SIZE - 1)) - 1;
    localparam int V_MAX_I = (1 << (VELOCITY_SIZE - 1)) - 1;

    localparam logic signed [W-1:0] P_MAX  = W'(P_MAX_I);
    localparam logic signed [W-1:0] P_MIN  = W'(-P_MAX_I - 1);
    localparam logic signed [W-1:0] V_MAX  = W'(V_MAX_I);
    localparam logic signed [W-1:0] V_MIN  = W'(-V_MAX_I - 1);
    localparam logic signed [W-1:0] GRAV_W = W'(GRAVITY);
    localparam logic signed [W-1:0] DT_W   = W'(DT);
    localparam logic signed [W-1:0] ZERO_W = '0;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t state, next_state;

    logic signed [POSITION_SIZE-1:0] work_p [NUM_BODIES][2][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] work_v [NUM_BODIES][2][NUM_NODES];
    logic signed [FORCE_SIZE-1:0]    work_f [NUM_BODIES][2][NUM_NODES];
    logic                            work_pin [NUM_BODIES][NUM_NODES];
    logic                            work_sat;

    logic [BW-1:0] body_idx;
    logic [NW-1:0] node_idx;
    logic          all_done;
    logic          last_node;

    logic signed [W-1:0] f_sh [2];
    logic signed [W-1:0] grav_term [2];
    logic signed [W-1:0] damp [2];
    logic signed [W-1:0] v_sum [2];
    logic signed [W-1:0] v_sat [2];
    logic signed [W-1:0] p_sum [2];
    logic signed [W-1:0] p_sat [2];
    logic                clip [2];

    logic signed [POSITION_SIZE-1:0] new_p [2];
    logic signed [VELOCITY_SIZE-1:0] new_v [2];
    logic                            node_sat;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (begin_in) next_state = STEP;
            STEP:    if (all_done) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign last_node = (node_idx == NW'(NUM_NODES - 1)) && (body_idx == BW'(NUM_BODIES - 1));

    // Velocity is updated first and the clamped value drives the position update.
    always_comb begin
        node_sat = 1'b0;
        for (int ax = 0; ax < 2; ax++) begin
            f_sh[ax]      = W'(work_f[body_idx][ax][node_idx]) >>> MASS_SHIFT;
            grav_term[ax] = (ax == 1) ? GRAV_W : ZERO_W;
            damp[ax]      = (DAMP_SHIFT != 0) ? (W'(work_v[body_idx][ax][node_idx]) >>> DAMP_SHIFT) : ZERO_W;
            v_sum[ax]     = W'(work_v[body_idx][ax][node_idx]) + (f_sh[ax] + grav_term[ax]) * DT_W - damp[ax];
            clip[ax]      = 1'b0;
            v_sat[ax]     = v_sum[ax];
            if (v_sum[ax] > V_MAX) begin
                v_sat[ax] = V_MAX;
                clip[ax]  = 1'b1;
            end else if (v_sum[ax] < V_MIN) begin
                v_sat[ax] = V_MIN;
                clip[ax]  = 1'b1;
            end
            p_sum[ax] = W'(work_p[body_idx][ax][node_idx]) + v_sat[ax] * DT_W;
            p_sat[ax] = p_sum[ax];
            if (p_sum[ax] > P_MAX) begin
                p_sat[ax] = P_MAX;
                clip[ax]  = 1'b1;
            end else if (p_sum[ax] < P_MIN) begin
                p_sat[ax] = P_MIN;
                clip[ax]  = 1'b1;
            end
            if (work_pin[body_idx][node_idx]) begin
                new_p[ax] = work_p[body_idx][ax][node_idx];
                new_v[ax] = '0;
            end else begin
                new_p[ax] = POSITION_SIZE'(p_sat[ax]);
                new_v[ax] = VELOCITY_SIZE'(v_sat[ax]);
                node_sat  = node_sat | clip[ax];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int b = 0; b < NUM_BODIES; b++)
                for (int ax = 0; ax < 2; ax++)
                    for (int n = 0; n < NUM_NODES; n++) begin
                        nodes_out[b][ax][n]      <= '0;
                        velocities_out[b][ax][n] <= '0;
                    end
            busy_out   <= 1'b0;
            result_out <= 1'b0;
            sat_out    <= 1'b0;
            work_sat   <= 1'b0;
            body_idx   <= '0;
            node_idx   <= '0;
            all_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (begin_in) begin
                        work_p <= nodes_in;
                        work_v <= velocities_in;
                        work_f <= forces_in;
                        for (int b = 0; b < NUM_BODIES; b++)
                            for (int n = 0; n < NUM_NODES; n++)
                                work_pin[b][n] <= pin_mask[b*NUM_NODES+n];
                        work_sat <= 1'b0;
                        body_idx <= '0;
                        node_idx <= '0;
                        all_done <= 1'b0;
                        busy_out <= 1'b1;
                    end
                end
                STEP: begin
                    if (!all_done) begin
                        for (int ax = 0; ax < 2; ax++) begin
                            work_p[body_idx][ax][node_idx] <= new_p[ax];
                            work_v[body_idx][ax][node_idx] <= new_v[ax];
                        end
                        work_sat <= work_sat | node_sat;
                        if (last_node) begin
                            all_done <= 1'b1;
                        end else if (node_idx == NW'(NUM_NODES - 1)) begin
                            node_idx <= '0;
                            body_idx <= body_idx + BW'(1);
                        end else begin
                            node_idx <= node_idx + NW'(1);
                        end
                    end else begin
                        // Publish the whole frame at once so consumers never see a partial update.
                        nodes_out      <= work_p;
                        velocities_out <= work_v;
                        sat_out        <= work_sat;
                        result_out     <= 1'b1;
                    end
                end
                DONE: begin
                    result_out <= 1'b0;
                    busy_out   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
